sreg_serial_tx: RTL



---
 rtl/sreg_serial_tx.sv | 116 +++++++++++
 1 files changed

// File: rtl/sreg_serial_tx.sv
// Parallel-in, serial-out byte transmitter: start bit, 8 data bits LSB first,
// optional parity bit, stop bit, each bit held for CLKS_PER_BIT clocks.
module sreg_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY       = 0,
    parameter bit          IDLE_LEVEL   = 1'b1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DIV_W    = 16;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLKS_PER_BIT - 2);
    localparam bit          CPB_ONE  = (CLKS_PER_BIT == 1);
    localparam bit          PAR_EN   = (PARITY == 1) || (PARITY == 2);
    localparam bit          PAR_ODD  = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state;
    logic [7:0]       shreg;
    logic [2:0]       bit_cnt;
    logic [DIV_W-1:0] div;
    logic             par_bit;

    // Frame sequencer: handshake capture, bit timing and all registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= S_IDLE;
            shreg     <= 8'h00;
            bit_cnt   <= 3'd0;
            div       <= '0;
            par_bit   <= 1'b0;
            tx_out    <= IDLE_LEVEL;
            ready_out <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (valid_in && ready_out) begin
                    shreg     <= data_in;
                    par_bit   <= (^data_in) ^ PAR_ODD;
                    bit_cnt   <= 3'd0;
                    div       <= '0;
                    state     <= S_START;
                    tx_out    <= ~IDLE_LEVEL;
                    ready_out <= 1'b0;
                    busy      <= 1'b1;
                end
            end else if (div != DIV_LAST) begin
                div <= div + DIV_W'(1);
                // done is registered, so raise it one cycle ahead of the last stop cycle
                if (state == S_STOP && !CPB_ONE && div == DIV_PRE) begin
                    done <= 1'b1;
                end
            end else begin
                div <= '0;
                case (state)
                    S_START: begin
                        state  <= S_DATA;
                        tx_out <= shreg[0];
                    end
                    S_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
                            if (PAR_EN) begin
                                state  <= S_PARITY;
                                tx_out <= par_bit;
                            end else begin
                                state  <= S_STOP;
                                tx_out <= IDLE_LEVEL;
                                done   <= CPB_ONE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= shreg >> 1;
                            tx_out  <= shreg[1];
                        end
                    end
                    S_PARITY: begin
                        state  <= S_STOP;
                        tx_out <= IDLE_LEVEL;
                        done   <= CPB_ONE;
                    end
                    S_STOP: begin
                        state     <= S_IDLE;
                        tx_out    <= IDLE_LEVEL;
                        ready_out <= 1'b1;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state     <= S_IDLE;
                        tx_out    <= IDLE_LEVEL;
                        ready_out <= 1'b1;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
